mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
// - Multi-cycle CPU control unit: Moore FSM sequencing IF/ID/EXE/MEM/WB per instruction.
// - Drives PC, IR, register file, ALU, data-memory and sign-extender (ExtSel) controls from opcode/flags.
// - Sits between the instruction register and the datapath; sole source of all write enables.
// PARAMETERS
// - OPW        6   opcode width (instr[31:26])
// - ALUOPW     3   ALU operation code width
// PORTS
// - clk        in   1       rising-edge clock
// - rst        in   1       synchronous, active-high reset
// - opcode     in   OPW     IR[31:26]; stable from ID until instruction end
// - zero       in   1       ALU result == 0 (from EXE_BR cycle)
// - PCWre      out  1       PC register write enable
// - IRWre      out  1       instruction register write enable
// - ExtSel     out  1       1 = sign-extend imm16, 0 = zero-extend
// - ALUSrcB    out  1       1 = extended immediate, 0 = rt
// - RegWre     out  1       register file write enable
// - RegDst     out  1       1 = rd, 0 = rt
// - WrDataSrc  out  1       1 = data memory, 0 = ALU result
// - mRD        out  1       data memory read; mWR out 1 data memory write
// - PCSrc      out  2       00 PC+4, 01 branch target, 10 jump target
// - ALUOp      out  ALUOPW  000 add, 001 sub, 010 and, 011 or, 100 slt
// - state      out  4       current state (debug)
// - halted     out  1       FSM in HALT
// BEHAVIOUR
// - Opcodes: add 000000, sub 000001, addi 000010, and 010000, andi 010001, ori 010010,
//   slt 011000, sw 100110, lw 100111, beq 110000, j 111000, halt 111111.
// - States: IF=0 ID=1 EXE_AL=2 WB_AL=3 EXE_BR=4 EXE_LS=5 MEM=6 WB_LD=7 HALT=8.
// - Transitions: IF->ID always. ID-> EXE_AL (ALU ops), EXE_LS (lw/sw), EXE_BR (beq),
//   IF (j), HALT (halt). EXE_AL->WB_AL->IF. EXE_LS->MEM. MEM->WB_LD (lw) / IF (sw).
//   WB_LD->IF. EXE_BR->IF. HALT->HALT until rst.
// - Cycles/instr: ALU 4, sw 4, lw 5, beq 3, j 2.
// - rst=1 at clock edge: state<=IF regardless of current state (aborts mid-instruction;
//   no write enable asserts in the reset cycle or following IF-entry cycle beyond IRWre).
// - Reset/IF outputs: IRWre=1; all other enables 0, PCSrc=00, ALUOp=000, ExtSel=0, halted=0.
// - Outputs are decoded from state + opcode (Moore w.r.t. state); write enables high
//   exactly one cycle per instruction: IRWre in IF; RegWre in WB_AL/WB_LD; mWR in MEM(sw).
// - PCWre=1 only in the final state of each instruction (WB_AL, WB_LD, MEM for sw, EXE_BR,
//   ID for j); PCSrc=01 in EXE_BR iff zero=1, 10 in ID for j, else 00.
// - ExtSel=1 for addi/lw/sw/beq; 0 for andi/ori and R-type. Held from ID through instruction end.
// - ALUSrcB=1 for immediate ops and lw/sw; RegDst=1 for R-type; WrDataSrc=1 only in WB_LD.
// - mRD=1 in MEM for lw only. beq uses ALUOp=sub in EXE_BR.
// - HALT: all enables 0, halted=1; opcode changes ignored.
// CONFIGURATION
// - MC_ILLEGAL_TRAP_EN defined: undefined opcode in ID -> HALT; extra output illegal (1b)
//   set on ID->HALT, held until rst.
// - Undefined: undefined opcode treated as NOP: ID->IF with PCWre=1, PCSrc=00; no illegal port.
// TESTING
// - rst 3 cycles then release, opcode=add -> states 0,1,2,3,0; IRWre @IF, RegWre+PCWre @WB_AL.
// - lw -> 5-cycle sequence 0,1,5,6,7; mRD=1 @MEM, WrDataSrc=1+RegWre=1 @WB_LD, ExtSel=1.
// - beq zero=1 -> PCSrc=01+PCWre @EXE_BR; zero=0 -> PCSrc=00, PCWre=1; 3 cycles.
// - ori -> ExtSel=0, ALUSrcB=1, ALUOp=011 from ID to WB_AL.
// - rst asserted during MEM of sw -> next state IF, mWR never pulses after rst edge.
// - opcode=101010: with MC_ILLEGAL_TRAP_EN -> HALT, illegal=1; without -> back to IF, PCWre=1.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control unit: Moore FSM stepping IF/ID/EXE/MEM/WB and decoding datapath controls.
// Optional MC_ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and raise the sticky illegal flag.
module mc_control_fsm #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              ExtSel,
  output logic              ALUSrcB,
  output logic              RegWre,
  output logic              RegDst,
  output logic              WrDataSrc,
  output logic              mRD,
  output logic              mWR,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [3:0]        state,
  output logic              halted
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM    = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100111);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  state_t state_reg;
  state_t cur;
  logic   is_r, is_imm, is_ls, is_lw, is_beq, is_j, is_halt, is_alu, known, in_instr;
  logic [2:0] aluop_c;

  always_comb begin
    is_r    = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) || (opcode == OP_SLT);
    is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    is_lw   = (opcode == OP_LW);
    is_ls   = is_lw || (opcode == OP_SW);
    is_beq  = (opcode == OP_BEQ);
    is_j    = (opcode == OP_J);
    is_halt = (opcode == OP_HALT);
    is_alu  = is_r || is_imm;
    known   = is_alu || is_ls || is_beq || is_j || is_halt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IF;
    end else begin
      case (state_reg)
        S_IF:     state_reg <= S_ID;
        S_ID: begin
          if (is_alu)       state_reg <= S_EXE_AL;
          else if (is_ls)   state_reg <= S_EXE_LS;
          else if (is_beq)  state_reg <= S_EXE_BR;
          else if (is_halt) state_reg <= S_HALT;
`ifdef MC_ILLEGAL_TRAP_EN
          else if (!known)  state_reg <= S_HALT;
`endif
          else              state_reg <= S_IF;
        end
        S_EXE_AL: state_reg <= S_WB_AL;
        S_EXE_LS: state_reg <= S_MEM;
        S_MEM:    state_reg <= is_lw ? S_WB_LD : S_IF;
        S_HALT:   state_reg <= S_HALT;
        default:  state_reg <= S_IF;
      endcase
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_reg;
  always_ff @(posedge clk) begin
    if (rst)
      illegal_reg <= 1'b0;
    else if (state_reg == S_ID && !known)
      illegal_reg <= 1'b1;
  end
  assign illegal = illegal_reg;
`endif

  // A cycle with rst high decodes as IF so an aborted instruction cannot fire a late write.
  assign cur      = rst ? S_IF : state_reg;
  assign in_instr = (cur != S_IF) && (cur != S_HALT);
  assign state    = state_reg;

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcB   = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    WrDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    aluop_c   = 3'b000;
    halted    = (cur == S_HALT);
    case (cur)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        if (is_j) begin
          PCWre = 1'b1;
          PCSrc = 2'b10;
        end
`ifndef MC_ILLEGAL_TRAP_EN
        else if (!known) PCWre = 1'b1;
`endif
      end
      S_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = {1'b0, zero};
      end
      S_MEM: begin
        if (is_lw) mRD = 1'b1;
        else begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        WrDataSrc = 1'b1;
      end
      default: ;
    endcase
    if (in_instr) begin
      ExtSel  = (opcode == OP_ADDI) || is_ls || is_beq;
      ALUSrcB = is_imm || is_ls;
      RegDst  = is_r;
      if ((opcode == OP_SUB) || is_beq)                           aluop_c = 3'b001;
      else if ((opcode == OP_AND) || (opcode == OP_ANDI))         aluop_c = 3'b010;
      else if (opcode == OP_ORI)                                  aluop_c = 3'b011;
      else if (opcode == OP_SLT)                                  aluop_c = 3'b100;
    end
  end

  assign ALUOp = ALUOPW'(aluop_c);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class and checks every control per cycle.
// Build with MC_ILLEGAL_TRAP_EN to exercise the trap variant.
module tb_mc_control_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, ExtSel, ALUSrcB, RegWre, RegDst, WrDataSrc, mRD, mWR, halted;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif
  logic [18:0] ctrl;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB),
    .RegWre(RegWre), .RegDst(RegDst), .WrDataSrc(WrDataSrc), .mRD(mRD), .mWR(mWR),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state), .halted(halted)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  assign ctrl = {PCWre, IRWre, ExtSel, ALUSrcB, RegWre, RegDst, WrDataSrc, mRD, mWR,
                 PCSrc, ALUOp, state, halted};

  // Expected control word, fields in the same order as ctrl.
  function automatic logic [18:0] ctl(input logic pcw, irw, ext, srcb, rw, rdst, wds, mrd, mwr,
                                      input logic [1:0] pcs, input logic [2:0] aop,
                                      input logic [3:0] st, input logic hlt);
    return {pcw, irw, ext, srcb, rw, rdst, wds, mrd, mwr, pcs, aop, st, hlt};
  endfunction

  localparam logic [18:0] IF_W = {9'b010000000, 2'b00, 3'b000, 4'd0, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b000000; zero = 1'b0;
    repeat (3) step();
    tests_run++;
    if (ctrl !== IF_W) begin tests_failed++; $display("FAIL reset_hold: got %b expected %b", ctrl, IF_W); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== IF_W) begin tests_failed++; $display("FAIL reset_release: got %b expected %b", ctrl, IF_W); end
  endtask

  task automatic test_add();
    logic [18:0] exp [4];
    opcode = 6'b000000; zero = 1'b1;
    exp[0] = ctl(0,0,0,0,0,1,0,0,0,2'b00,3'b000,4'd1,0);
    exp[1] = ctl(0,0,0,0,0,1,0,0,0,2'b00,3'b000,4'd2,0);
    exp[2] = ctl(1,0,0,0,1,1,0,0,0,2'b00,3'b000,4'd3,0);
    exp[3] = IF_W;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (ctrl !== exp[i]) begin tests_failed++; $display("FAIL add_cyc%0d: got %b expected %b", i + 1, ctrl, exp[i]); end
    end
    zero = 1'b0;
  endtask

  task automatic test_lw();
    logic [18:0] exp [5];
    opcode = 6'b100111;
    exp[0] = ctl(0,0,1,1,0,0,0,0,0,2'b00,3'b000,4'd1,0);
    exp[1] = ctl(0,0,1,1,0,0,0,0,0,2'b00,3'b000,4'd5,0);
    exp[2] = ctl(0,0,1,1,0,0,0,1,0,2'b00,3'b000,4'd6,0);
    exp[3] = ctl(1,0,1,1,1,0,1,0,0,2'b00,3'b000,4'd7,0);
    exp[4] = IF_W;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (ctrl !== exp[i]) begin tests_failed++; $display("FAIL lw_cyc%0d: got %b expected %b", i + 1, ctrl, exp[i]); end
    end
  endtask

  task automatic test_beq();
    logic [18:0] exp;
    opcode = 6'b110000;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      step();
      exp = ctl(0,0,1,0,0,0,0,0,0,2'b00,3'b001,4'd1,0);
      tests_run++;
      if (ctrl !== exp) begin tests_failed++; $display("FAIL beq_id_z%0d: got %b expected %b", z, ctrl, exp); end
      step();
      exp = ctl(1,0,1,0,0,0,0,0,0,{1'b0, z[0]},3'b001,4'd4,0);
      tests_run++;
      if (ctrl !== exp) begin tests_failed++; $display("FAIL beq_exe_z%0d: got %b expected %b", z, ctrl, exp); end
      step();
      tests_run++;
      if (ctrl !== IF_W) begin tests_failed++; $display("FAIL beq_end_z%0d: got %b expected %b", z, ctrl, IF_W); end
    end
    zero = 1'b0;
  endtask

  task automatic test_ori();
    logic [18:0] exp [4];
    opcode = 6'b010010;
    exp[0] = ctl(0,0,0,1,0,0,0,0,0,2'b00,3'b011,4'd1,0);
    exp[1] = ctl(0,0,0,1,0,0,0,0,0,2'b00,3'b011,4'd2,0);
    exp[2] = ctl(1,0,0,1,1,0,0,0,0,2'b00,3'b011,4'd3,0);
    exp[3] = IF_W;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (ctrl !== exp[i]) begin tests_failed++; $display("FAIL ori_cyc%0d: got %b expected %b", i + 1, ctrl, exp[i]); end
    end
  endtask

  task automatic test_sw_full();
    logic [18:0] exp [4];
    opcode = 6'b100110;
    exp[0] = ctl(0,0,1,1,0,0,0,0,0,2'b00,3'b000,4'd1,0);
    exp[1] = ctl(0,0,1,1,0,0,0,0,0,2'b00,3'b000,4'd5,0);
    exp[2] = ctl(1,0,1,1,0,0,0,0,1,2'b00,3'b000,4'd6,0);
    exp[3] = IF_W;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (ctrl !== exp[i]) begin tests_failed++; $display("FAIL sw_cyc%0d: got %b expected %b", i + 1, ctrl, exp[i]); end
    end
  endtask

  task automatic test_sw_reset();
    logic [18:0] exp;
    opcode = 6'b100110;
    repeat (3) step();
    tests_run++;
    if (state !== 4'd6) begin tests_failed++; $display("FAIL swrst_in_mem: got state %0d expected 6", state); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({mWR, PCWre, IRWre} !== 3'b001) begin
      tests_failed++; $display("FAIL swrst_rst_cycle: got mWR/PCWre/IRWre %b expected 001", {mWR, PCWre, IRWre});
    end
    step();
    tests_run++;
    if (ctrl !== IF_W) begin tests_failed++; $display("FAIL swrst_after_edge: got %b expected %b", ctrl, IF_W); end
    rst = 1'b0;
    step();
    exp = ctl(0,0,1,1,0,0,0,0,0,2'b00,3'b000,4'd1,0);
    tests_run++;
    if (ctrl !== exp) begin tests_failed++; $display("FAIL swrst_restart_id: got %b expected %b", ctrl, exp); end
    do_reset();
  endtask

  task automatic test_j();
    logic [18:0] exp;
    opcode = 6'b111000;
    step();
    exp = ctl(1,0,0,0,0,0,0,0,0,2'b10,3'b000,4'd1,0);
    tests_run++;
    if (ctrl !== exp) begin tests_failed++; $display("FAIL j_id: got %b expected %b", ctrl, exp); end
    step();
    tests_run++;
    if (ctrl !== IF_W) begin tests_failed++; $display("FAIL j_end: got %b expected %b", ctrl, IF_W); end
  endtask

  task automatic test_illegal();
    logic [18:0] exp;
    opcode = 6'b101010;
    step();
`ifdef MC_ILLEGAL_TRAP_EN
    exp = ctl(0,0,0,0,0,0,0,0,0,2'b00,3'b000,4'd1,0);
`else
    exp = ctl(1,0,0,0,0,0,0,0,0,2'b00,3'b000,4'd1,0);
`endif
    tests_run++;
    if (ctrl !== exp) begin tests_failed++; $display("FAIL illegal_id: got %b expected %b", ctrl, exp); end
    step();
`ifdef MC_ILLEGAL_TRAP_EN
    exp = ctl(0,0,0,0,0,0,0,0,0,2'b00,3'b000,4'd8,1);
    tests_run++;
    if ({ctrl, illegal} !== {exp, 1'b1}) begin
      tests_failed++; $display("FAIL illegal_trap: got %b/%b expected %b/1", ctrl, illegal, exp);
    end
    do_reset();
    tests_run++;
    if (illegal !== 1'b0) begin tests_failed++; $display("FAIL illegal_clear: got %b expected 0", illegal); end
`else
    tests_run++;
    if (ctrl !== IF_W) begin tests_failed++; $display("FAIL illegal_nop_end: got %b expected %b", ctrl, IF_W); end
`endif
  endtask

  task automatic test_halt();
    logic [18:0] exp;
    opcode = 6'b111111;
    step();
    exp = ctl(0,0,0,0,0,0,0,0,0,2'b00,3'b000,4'd1,0);
    tests_run++;
    if (ctrl !== exp) begin tests_failed++; $display("FAIL halt_id: got %b expected %b", ctrl, exp); end
    exp = ctl(0,0,0,0,0,0,0,0,0,2'b00,3'b000,4'd8,1);
    step();
    opcode = 6'b100110; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ctrl !== exp) begin tests_failed++; $display("FAIL halt_hold%0d: got %b expected %b", i, ctrl, exp); end
      step();
    end
    zero = 1'b0;
    do_reset();
    tests_run++;
    if (ctrl !== IF_W) begin tests_failed++; $display("FAIL halt_reset: got %b expected %b", ctrl, IF_W); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_ori();
    test_sw_full();
    test_sw_reset();
    test_j();
    test_illegal();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
